// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// line levels and parity selection.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // data_xor is the XOR-reduction of the data byte.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_EVEN) ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port, frame configuration and serial line of the UART transmitter.
// master = FIFO/config side, slave = transmitter.
interface fifo_uart_tx_if #(parameter int WIDTH = 8);

  logic             rempty;
  logic [WIDTH-1:0] rdata;
  logic             par_en;
  logic             par_typ;
  logic             rinc;
  logic             tx_out;
  logic             busy;

  modport master (
    output rempty, rdata, par_en, par_typ,
    input  rinc, tx_out, busy
  );

  modport slave (
    input  rempty, rdata, par_en, par_typ,
    output rinc, tx_out, busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// Shift register, bit counter and registered line driver. The line value is
// chosen from the state being entered, so tx_out changes together with the state.
module uart_tx_serializer
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  state_t           i_state,
  input  state_t           i_state_next,
  input  logic             i_par_bit,
  output logic             o_tx,
  output logic             o_last_bit
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tx;
  logic             w_tx_next;

  always_comb begin
    w_tx_next = STOP_BIT;
    case (i_state_next)
      START:   w_tx_next = START_BIT;
      DATA:    w_tx_next = r_shift[0];
      PARITY:  w_tx_next = i_par_bit;
      default: w_tx_next = STOP_BIT;
    endcase
  end

  // Each edge into a DATA cycle drives the current LSB and shifts it out.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_tx    <= STOP_BIT;
    end else begin
      if (i_load) begin
        r_shift <= i_data;
      end else if (i_state_next == DATA) begin
        r_shift <= r_shift >> 1;
      end
      if (i_state == DATA && i_state_next == DATA) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      r_tx <= w_tx_next;
    end
  end

  assign o_tx       = r_tx;
  assign o_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops a byte whenever the FIFO is non-empty and the
// line is free (idle or stop bit), then sends start, data LSB first, parity, stop.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  fifo_uart_tx_if.slave  fifo_if
);

  state_t r_state;
  state_t w_state_next;
  logic   r_busy;
  logic   r_par_en;
  logic   r_par_bit;
  logic   w_rinc;
  logic   w_last_bit;
  logic   w_tx;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
      if (w_rinc) begin
        r_par_en  <= fifo_if.par_en;
        r_par_bit <= parity_bit(^fifo_if.rdata, fifo_if.par_typ);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_rinc ? START : IDLE;
      START:   w_state_next = DATA;
      DATA:    if (w_last_bit) w_state_next = r_par_en ? PARITY : STOP;
      PARITY:  w_state_next = STOP;
      STOP:    w_state_next = w_rinc ? START : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Gated by RST so a pop never happens on an edge that discards the byte.
  always_comb begin
    w_rinc = RST && !fifo_if.rempty && (r_state == IDLE || r_state == STOP);
  end

  uart_tx_serializer #(
    .WIDTH (WIDTH)
  ) u_serializer (
    .i_clk        (CLK),
    .i_rst_n      (RST),
    .i_load       (w_rinc),
    .i_data       (fifo_if.rdata),
    .i_state      (r_state),
    .i_state_next (w_state_next),
    .i_par_bit    (r_par_bit),
    .o_tx         (w_tx),
    .o_last_bit   (w_last_bit)
  );

  assign fifo_if.rinc   = w_rinc;
  assign fifo_if.tx_out = w_tx;
  assign fifo_if.busy   = r_busy;

endmodule
